// File: rtl/uart_tx_framer.sv
// UART transmit framer: a small character FIFO feeding a start/data/parity/stop serialiser.
// Each character carries its own frame format, captured from cfg_* when it leaves the FIFO.
module uart_tx_framer #(
  parameter int MAX_CHAR_LENGTH = 8,
  parameter int DIV_WIDTH       = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         pclk,
  input  logic                         areset,
  input  logic                         in_valid,
  input  logic [MAX_CHAR_LENGTH-1:0]   in_data,
  output logic                         in_ready,
  input  logic [DIV_WIDTH-1:0]         cfg_divisor,
  input  logic [3:0]                   cfg_oversampling,
  input  logic [3:0]                   cfg_uart_type,
  input  logic                         cfg_msb_first,
  input  logic                         cfg_parity_en,
  input  logic                         cfg_parity_scheme,
  input  logic [1:0]                   cfg_stop_bit,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         char_done,
  output logic                         drop_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PER_W = DIV_WIDTH + 4;
  localparam int TMR_W = PER_W + 1;
  localparam int IDX_W = $clog2(MAX_CHAR_LENGTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  function automatic logic [PER_W-1:0] bit_period(input logic [DIV_WIDTH-1:0] div,
                                                  input logic [3:0] os);
    logic [DIV_WIDTH-1:0] d;
    logic [3:0]           o;
    d = (div == '0) ? DIV_WIDTH'(1) : div;
    o = (os == 4'd0) ? 4'd1 : os;
    return PER_W'(d) * PER_W'(o);
  endfunction

  function automatic logic [TMR_W-1:0] stop_len(input logic [PER_W-1:0] t,
                                                input logic [1:0] sb);
    logic [TMR_W-1:0] r;
    case (sb)
      2'd0:    r = TMR_W'(t) + TMR_W'(t >> 1);
      2'd2:    r = {t, 1'b0};
      default: r = TMR_W'(t);
    endcase
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] char_len(input logic [3:0] ut);
    if (int'(ut) > MAX_CHAR_LENGTH) return IDX_W'(MAX_CHAR_LENGTH);
    return IDX_W'(ut);
  endfunction

  function automatic logic [MAX_CHAR_LENGTH-1:0] char_mask(input logic [IDX_W-1:0] n);
    return ~({MAX_CHAR_LENGTH{1'b1}} << n);
  endfunction

  // Bits are arranged so the serialiser always shifts out bit 0 first.
  function automatic logic [MAX_CHAR_LENGTH-1:0] order_bits(input logic [MAX_CHAR_LENGTH-1:0] d,
                                                            input logic [IDX_W-1:0] n,
                                                            input logic msb);
    logic [MAX_CHAR_LENGTH-1:0] rev;
    for (int i = 0; i < MAX_CHAR_LENGTH; i++) rev[i] = d[MAX_CHAR_LENGTH-1-i];
    if (msb) return rev >> (IDX_W'(MAX_CHAR_LENGTH) - n);
    return d & char_mask(n);
  endfunction

  function automatic logic parity_of(input logic [MAX_CHAR_LENGTH-1:0] d,
                                     input logic [IDX_W-1:0] n,
                                     input logic odd);
    return (^(d & char_mask(n))) ^ odd;
  endfunction

  logic [MAX_CHAR_LENGTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       push, pop, empty;

  state_t                     state, state_n;
  logic [TMR_W-1:0]           tmr;
  logic [IDX_W-1:0]           idx;
  logic                       last, tx_n;
  logic [IDX_W-1:0]           n_live;
  logic [PER_W-1:0]           period_live;

  logic [MAX_CHAR_LENGTH-1:0] shreg_p1;
  logic                       par_p1, par_en_p1;
  logic [IDX_W-1:0]           n_p1;
  logic [PER_W-1:0]           period_p1;
  logic [TMR_W-1:0]           stop_p1;

  assign empty       = (count == '0);
  assign in_ready    = (count != CNT_W'(FIFO_DEPTH));
  assign push        = in_valid && in_ready;
  assign fifo_count  = count;
  assign last        = (tmr == '0);
  assign n_live      = char_len(cfg_uart_type);
  assign period_live = bit_period(cfg_divisor, cfg_oversampling);

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Stage p1: character and frame format captured at pop, held for the whole frame
  always_ff @(posedge pclk) begin
    if (pop) begin
      shreg_p1  <= order_bits(mem[rd_ptr], n_live, cfg_msb_first);
      par_p1    <= parity_of(mem[rd_ptr], n_live, cfg_parity_scheme);
      n_p1      <= n_live;
      par_en_p1 <= cfg_parity_en;
      period_p1 <= period_live;
      stop_p1   <= stop_len(period_live, cfg_stop_bit);
    end else if (state == DATA && last) begin
      shreg_p1  <= shreg_p1 >> 1;
    end
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (cfg_uart_type != 4'd0) state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (last) state_n = DATA;
      end
      DATA: begin
        tx_n = shreg_p1[0];
        if (last && idx == n_p1 - IDX_W'(1)) state_n = par_en_p1 ? PARITY : STOP;
      end
      PARITY: begin
        tx_n = par_p1;
        if (last) state_n = STOP;
      end
      STOP: begin
        // Chain straight into the next frame so back-to-back characters have no idle gap.
        if (last) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = (cfg_uart_type != 4'd0) ? START : IDLE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage p2: registered line outputs, one cycle behind the FSM state
  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      tmr       <= '0;
      idx       <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      char_done <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      state     <= state_n;
      tx        <= tx_n;
      busy      <= (state != IDLE);
      char_done <= (state == STOP) && last;
      drop_err  <= pop && (cfg_uart_type == 4'd0);
      if (pop) begin
        tmr <= TMR_W'(period_live) - TMR_W'(1);
        idx <= '0;
      end else if (last) begin
        case (state_n)
          START, DATA, PARITY: tmr <= TMR_W'(period_p1) - TMR_W'(1);
          STOP:                tmr <= stop_p1 - TMR_W'(1);
          default:             tmr <= '0;
        endcase
        if (state == DATA) idx <= idx + IDX_W'(1);
      end else begin
        tmr <= tmr - TMR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: expected tx waveforms are queued at write time
// and consumed cycle by cycle while the framer reports busy.
module tb_uart_tx_framer;

  logic        pclk = 1'b0;
  logic        areset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [15:0] cfg_divisor = 16'd1;
  logic [3:0]  cfg_oversampling = 4'd2;
  logic [3:0]  cfg_uart_type = 4'd8;
  logic        cfg_msb_first = 1'b0;
  logic        cfg_parity_en = 1'b0;
  logic        cfg_parity_scheme = 1'b0;
  logic [1:0]  cfg_stop_bit = 2'd1;
  logic        tx, busy, char_done, drop_err;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  bit exp_tx[$];
  int len_q[$];
  int frame_cyc = 0;
  int drop_cnt = 0;
  bit prev_done = 1'b0;

  uart_tx_framer #(.MAX_CHAR_LENGTH(8), .DIV_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .pclk(pclk), .areset(areset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cfg_divisor(cfg_divisor), .cfg_oversampling(cfg_oversampling), .cfg_uart_type(cfg_uart_type),
    .cfg_msb_first(cfg_msb_first), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_scheme(cfg_parity_scheme), .cfg_stop_bit(cfg_stop_bit),
    .tx(tx), .busy(busy), .fifo_count(fifo_count), .char_done(char_done), .drop_err(drop_err)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference frame built straight from the frame rules and the current cfg.
  task automatic push_frame(input logic [7:0] d);
    int t, n, sl;
    bit p, b;
    t = (cfg_divisor == '0 ? 1 : int'(cfg_divisor)) *
        (cfg_oversampling == '0 ? 1 : int'(cfg_oversampling));
    n = (int'(cfg_uart_type) > 8) ? 8 : int'(cfg_uart_type);
    if (n == 0) return;
    repeat (t) exp_tx.push_back(1'b0);
    p = cfg_parity_scheme;
    for (int i = 0; i < n; i++) begin
      b = cfg_msb_first ? d[3'(n-1-i)] : d[3'(i)];
      p = p ^ b;
      repeat (t) exp_tx.push_back(b);
    end
    if (cfg_parity_en) repeat (t) exp_tx.push_back(p);
    case (cfg_stop_bit)
      2'd0:    sl = t + t / 2;
      2'd2:    sl = 2 * t;
      default: sl = t;
    endcase
    repeat (sl) exp_tx.push_back(1'b1);
    len_q.push_back(t * (1 + n + (cfg_parity_en ? 1 : 0)) + sl);
  endtask

  task automatic sync_in();
    @(posedge pclk);
    #1;
  endtask

  // Call aligned 1ns after a rising edge; returns 1ns after the accepting edge.
  task automatic write_char(input logic [7:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(posedge pclk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("wr_timeout", 32'(in_ready), 32'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge pclk);
    #1;
    in_valid = 1'b0;
    push_frame(d);
  endtask

  task automatic wait_idle();
    int n = 0;
    int streak = 0;
    while (streak < 4 && n < 2000) begin
      @(negedge pclk);
      n++;
      if (!busy && fifo_count == 3'd0) streak++;
      else streak = 0;
    end
    if (streak < 4) check("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic wait_busy();
    int n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!busy && n < 100);
    if (!busy) check("busy_timeout", 32'(busy), 32'(1));
  endtask

  always @(negedge pclk) begin
    if (!areset) begin
      if (prev_done && exp_tx.size() > 0) check("contig", 32'(busy), 32'(1));
      if (busy) begin
        frame_cyc++;
        if (exp_tx.size() == 0) check("tx_extra", 32'(busy), 32'(0));
        else check("tx", 32'(tx), 32'(exp_tx.pop_front()));
      end else begin
        check("tx_idle", 32'(tx), 32'(1));
      end
      if (char_done) begin
        check("done_busy", 32'(busy), 32'(1));
        if (len_q.size() == 0) check("done_extra", 32'(char_done), 32'(0));
        else check("frame_len", 32'(frame_cyc), 32'(len_q.pop_front()));
        frame_cyc = 0;
      end
      if (drop_err) drop_cnt++;
      prev_done = char_done;
    end else begin
      prev_done = 1'b0;
      frame_cyc = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, n;
    int fifo_exp [5] = '{3, 2, 1, 0, 0};

    repeat (3) @(posedge pclk);
    #1;
    check("rst_tx", 32'(tx), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ready", 32'(in_ready), 32'(1));
    check("rst_count", 32'(fifo_count), 32'(0));
    check("rst_done", 32'(char_done), 32'(0));
    check("rst_drop", 32'(drop_err), 32'(0));
    areset = 1'b0;
    sync_in();

    // 8N1 LSB-first, T=2, with first-frame latency
    write_char(8'hA5);
    @(negedge pclk);
    check("lat_count_k", 32'(fifo_count), 32'(1));
    check("lat_busy_k", 32'(busy), 32'(0));
    @(negedge pclk);
    check("lat_count_k1", 32'(fifo_count), 32'(0));
    check("lat_tx_k1", 32'(tx), 32'(1));
    @(negedge pclk);
    check("lat_busy_k2", 32'(busy), 32'(1));
    check("lat_tx_k2", 32'(tx), 32'(0));
    wait_idle();

    // 7-bit MSB-first with even then odd parity, T=4
    cfg_oversampling  = 4'd4;
    cfg_uart_type     = 4'd7;
    cfg_msb_first     = 1'b1;
    cfg_parity_en     = 1'b1;
    cfg_parity_scheme = 1'b0;
    sync_in();
    write_char(8'h35);
    wait_idle();
    cfg_parity_scheme = 1'b1;
    sync_in();
    write_char(8'h35);
    wait_idle();

    // One-and-half then two stop bits, T=8; cfg changed mid-frame must not matter
    cfg_divisor   = 16'd2;
    cfg_uart_type = 4'd8;
    cfg_msb_first = 1'b0;
    cfg_parity_en = 1'b0;
    cfg_stop_bit  = 2'd0;
    sync_in();
    write_char(8'hC3);
    wait_busy();
    cfg_divisor  = 16'd1;
    cfg_stop_bit = 2'd1;
    wait_idle();
    cfg_divisor  = 16'd2;
    cfg_stop_bit = 2'd2;
    sync_in();
    write_char(8'h3C);
    wait_idle();

    // FIFO fill and back-to-back frames, T=2
    cfg_divisor      = 16'd1;
    cfg_oversampling = 4'd2;
    cfg_stop_bit     = 2'd1;
    sync_in();
    for (int i = 0; i < 5; i++) write_char(8'(8'h10 + i));
    check("full_count", 32'(fifo_count), 32'(4));
    check("full_ready", 32'(in_ready), 32'(0));
    for (int i = 0; i < 5; i++) begin
      n = 0;
      do begin
        @(negedge pclk);
        n++;
      end while (!char_done && n < 200);
      if (!char_done) check("done_timeout", 32'(char_done), 32'(1));
      else check("fifo_dec", 32'(fifo_count), 32'(fifo_exp[i]));
    end
    wait_idle();

    // Drop of a character with uart_type 0
    cfg_uart_type = 4'd0;
    d0 = drop_cnt;
    sync_in();
    write_char(8'h12);
    repeat (8) begin
      @(negedge pclk);
      check("drop_busy", 32'(busy), 32'(0));
    end
    check("drop_pulses", 32'(drop_cnt - d0), 32'(1));
    check("drop_count", 32'(fifo_count), 32'(0));

    // Reset during data bit 3 with two characters queued
    cfg_uart_type    = 4'd8;
    cfg_oversampling = 4'd4;
    sync_in();
    write_char(8'h55);
    wait_busy();
    sync_in();
    write_char(8'h66);
    write_char(8'h77);
    n = 0;
    do begin
      @(negedge pclk);
      #2;
      n++;
    end while (frame_cyc < 18 && n < 200);
    check("pre_rst_cycle", 32'(frame_cyc), 32'(18));
    check("pre_rst_count", 32'(fifo_count), 32'(2));
    check("pre_rst_tx", 32'(tx), 32'(0));
    areset = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx), 32'(1));
    check("mid_rst_count", 32'(fifo_count), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    exp_tx.delete();
    len_q.delete();
    repeat (2) @(negedge pclk);
    #1;
    areset = 1'b0;
    cfg_uart_type = 4'd5;
    sync_in();
    write_char(8'h0F);
    wait_idle();

    check("exp_drained", 32'(exp_tx.size()), 32'(0));
    check("len_drained", 32'(len_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
